// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with PC sequencing and branch redirect.
// Optional feature macro: IF_TIMEOUT_EN (fetch timeout counter, ERROR state, sticky o_fetch_err).
// Ports:
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   o_pc             address of the instruction being fetched or held
//   o_mem_read       read request to instruction memory
//   o_mem_address    read address (always o_pc)
//   i_mem_readdata   instruction word from memory
//   i_mem_busywait   memory not ready
//   o_instruction    fetched instruction presented to the core
//   o_instr_valid    o_instruction valid and waiting for the core
//   i_core_stall     core cannot accept this cycle
//   i_branch_en      accepted instruction redirects the PC
//   i_branch_offset  signed word offset applied on branch
//   o_fetch_err      sticky fetch-timeout flag (0 when IF_TIMEOUT_EN undefined)
module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_pc,
    output logic        o_mem_read,
    output logic [31:0] o_mem_address,
    input  logic [31:0] i_mem_readdata,
    input  logic        i_mem_busywait,
    output logic [31:0] o_instruction,
    output logic        o_instr_valid,
    input  logic        i_core_stall,
    input  logic        i_branch_en,
    input  logic [7:0]  i_branch_offset,
    output logic        o_fetch_err
);
`ifdef IF_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, FETCH, VALID, ERROR} state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_fetch_err;
    assign o_fetch_err = r_fetch_err;
`else
    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
    assign o_fetch_err = 1'b0;
`endif
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instruction;
    logic        r_mem_read;
    logic        r_instr_valid;
    logic [31:0] w_next_pc;

    // Branch offset counts words, so it is sign-extended and scaled by 4.
    assign w_next_pc = r_pc + 32'd4 +
                       (i_branch_en ? {{22{i_branch_offset[7]}}, i_branch_offset, 2'b00} : 32'd0);

    assign o_pc          = r_pc;
    assign o_mem_address = r_pc;
    assign o_mem_read    = r_mem_read;
    assign o_instruction = r_instruction;
    assign o_instr_valid = r_instr_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instruction <= 32'd0;
            r_mem_read    <= 1'b0;
            r_instr_valid <= 1'b0;
`ifdef IF_TIMEOUT_EN
            r_cnt         <= '0;
            r_fetch_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_state    <= FETCH;
                    r_mem_read <= 1'b1;
                end
                FETCH: begin
                    if (!i_mem_busywait) begin
                        r_instruction <= i_mem_readdata;
                        r_state       <= VALID;
                        r_mem_read    <= 1'b0;
                        r_instr_valid <= 1'b1;
`ifdef IF_TIMEOUT_EN
                        r_cnt         <= '0;
                    end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        // This busy edge is the TIMEOUT_CYCLES-th in a row.
                        r_state     <= ERROR;
                        r_mem_read  <= 1'b0;
                        r_fetch_err <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
`endif
                    end
                end
                VALID: begin
                    if (!i_core_stall) begin
                        r_pc          <= w_next_pc;
                        r_state       <= FETCH;
                        r_mem_read    <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end
                end
                // ERROR (when compiled in) holds until reset.
                default: r_state <= r_state;
            endcase
        end
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, fetch-timeout limit in cycles (used only under IF_TIMEOUT_EN, see REQ-030).
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 PC  output  32  address of the instruction currently fetched or held.
REQ-006 MEM_READ  output  1  read request to instruction memory.
REQ-007 MEM_ADDRESS  output  32  read address; always equal to PC.
REQ-008 MEM_READDATA  input  32  instruction word returned by memory.
REQ-009 MEM_BUSYWAIT  input  1  memory not ready; a read completes on a rising edge where MEM_READ=1 and MEM_BUSYWAIT=0.
REQ-010 INSTRUCTION  output  32  fetched instruction word presented to the core.
REQ-011 INSTR_VALID  output  1  INSTRUCTION is valid and waiting for the core.
REQ-012 CORE_STALL  input  1  core cannot accept the instruction this cycle.
REQ-013 BRANCH_EN  input  1  the accepted instruction redirects the PC.
REQ-014 BRANCH_OFFSET  input  8  signed word offset, applied when BRANCH_EN=1.
REQ-015 FETCH_ERR  output  1  sticky fetch-timeout flag.

Function
REQ-016 The FSM SHALL have four states: IDLE, FETCH, VALID, ERROR.
REQ-017 IDLE SHALL be entered on reset and SHALL advance to FETCH on the first rising edge with RESET=1.
REQ-018 In FETCH:
- MEM_READ=1 and INSTR_VALID=0.
- On a completing edge, MEM_READDATA SHALL be latched into INSTRUCTION and the state SHALL move to VALID; with zero-wait memory this takes one cycle.
REQ-019 In VALID:
- MEM_READ=0 and INSTR_VALID=1.
- INSTRUCTION and PC SHALL stay stable until an accept edge (INSTR_VALID=1 and CORE_STALL=0).
REQ-020 On an accept edge, PC SHALL be loaded with the next PC and the state SHALL return to FETCH, so one instruction is delivered per two cycles at best.
REQ-021 Next PC SHALL be:
- PC+4 when BRANCH_EN=0.
- PC+4+(sign-extended BRANCH_OFFSET shifted left by 2) when BRANCH_EN=1.
- Both computed modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-022 BRANCH_EN and BRANCH_OFFSET SHALL be sampled only on an accept edge; at all other times they SHALL be ignored.
REQ-023 MEM_BUSYWAIT and MEM_READDATA SHALL be ignored outside FETCH.
REQ-024 MEM_ADDRESS SHALL stay constant for the whole of any FETCH period.

Reset
REQ-025 RESET=0 SHALL immediately set, without waiting for a clock edge:
- state IDLE, PC=RESET_PC, INSTRUCTION=0;
- MEM_READ=0, INSTR_VALID=0, FETCH_ERR=0;
- timeout counter=0.
REQ-026 Reset asserted mid-fetch SHALL abort the read (MEM_READ falls asynchronously); the returned data SHALL be discarded.
REQ-027 After reset release, the first fetch SHALL be from RESET_PC.

Configuration
REQ-028 Macro IF_TIMEOUT_EN SHALL compile the fetch timeout in or out.
REQ-029 With IF_TIMEOUT_EN defined:
- A counter SHALL count consecutive FETCH cycles with MEM_BUSYWAIT=1; it SHALL clear on leaving FETCH.
- On the edge where the count reaches TIMEOUT_CYCLES, the block SHALL set FETCH_ERR=1, set MEM_READ=0 and enter ERROR.
- ERROR SHALL hold until reset.
REQ-030 Without IF_TIMEOUT_EN:
- No counter, no ERROR state, and TIMEOUT_CYCLES unused.
- FETCH_ERR SHALL be tied to 0.
- FETCH SHALL wait indefinitely.

Verification
REQ-031 Reset, then release; zero-wait memory returns 32'h0004_0005 at address 0 -> MEM_READ=1 after the first edge; INSTR_VALID=1 with INSTRUCTION=32'h0004_0005 and PC=0 after the second edge.
REQ-032 MEM_BUSYWAIT high for 3 cycles -> MEM_ADDRESS stable throughout; INSTR_VALID rises on the edge where MEM_BUSYWAIT is first seen at 0.
REQ-033 CORE_STALL=1 for 2 cycles while in VALID -> INSTRUCTION and PC held; accept with BRANCH_EN=0 -> PC=4.
REQ-034 Branches: PC=8 with BRANCH_OFFSET=8'hFE -> PC=4; PC=0 with BRANCH_OFFSET=8'h7F -> PC=32'h0000_0200; PC=32'hFFFF_FFFC with no branch -> PC=0.
REQ-035 RESET driven low during FETCH, between clock edges -> MEM_READ, INSTR_VALID and PC=RESET_PC take effect immediately.
REQ-036 With IF_TIMEOUT_EN defined, MEM_BUSYWAIT stuck at 1 -> FETCH_ERR=1 and MEM_READ=0 on the 255th FETCH edge; both held until reset.
